// File: rtl/sdram_pkg.sv
// Shared SDRAM command codes, pin patterns and helpers for the core FSM and the command PHY.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP   = 4'h0;
    localparam logic [3:0] CMD_DESL  = 4'h1;
    localparam logic [3:0] CMD_MRS   = 4'h2;
    localparam logic [3:0] CMD_ACT   = 4'h3;
    localparam logic [3:0] CMD_READ  = 4'h4;
    localparam logic [3:0] CMD_READA = 4'h5;
    localparam logic [3:0] CMD_WRIT  = 4'h6;
    localparam logic [3:0] CMD_WRITA = 4'h7;
    localparam logic [3:0] CMD_PRE   = 4'h8;
    localparam logic [3:0] CMD_PALL  = 4'h9;
    localparam logic [3:0] CMD_BST   = 4'hA;
    localparam logic [3:0] CMD_REF   = 4'hB;
    localparam logic [3:0] CMD_SELF  = 4'hC;
    localparam logic [3:0] CMD_SUP   = 4'hD;
    localparam logic [3:0] CMD_REC   = 4'hE;
    localparam logic [3:0] CMD_ILL   = 4'hF;

    // {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] PIN_DESL  = 4'b1111;
    localparam logic [3:0] PIN_NOP   = 4'b0111;
    localparam logic [3:0] PIN_MRS   = 4'b0000;
    localparam logic [3:0] PIN_ACT   = 4'b0011;
    localparam logic [3:0] PIN_READ  = 4'b0101;
    localparam logic [3:0] PIN_WRIT  = 4'b0100;
    localparam logic [3:0] PIN_PRE   = 4'b0010;
    localparam logic [3:0] PIN_BST   = 4'b0110;
    localparam logic [3:0] PIN_REF   = 4'b0001;

    localparam int A10 = 10;

    function automatic logic is_read(input logic [3:0] c);
        return (c == CMD_READ) || (c == CMD_READA);
    endfunction

    function automatic logic is_write(input logic [3:0] c);
        return (c == CMD_WRIT) || (c == CMD_WRITA);
    endfunction

endpackage

// File: rtl/sdram_cmd_phy_if.sv
// Core-side command bus of the SDRAM command PHY: abstract command, address, write data, read return.
interface sdram_cmd_phy_if #(
    parameter int ROW_BITS   = 12,
    parameter int COL_BITS   = 9,
    parameter int BANK_BITS  = 2,
    parameter int DATA_WIDTH = 16
);
    logic [3:0]                          cmd;
    logic [BANK_BITS+ROW_BITS+COL_BITS-1:0] addr;
    logic [DATA_WIDTH-1:0]               wr_data;
    logic [DATA_WIDTH/8-1:0]             wr_mask;
    logic [DATA_WIDTH-1:0]               rd_data;
    logic                                rd_valid;

    modport master (output cmd, addr, wr_data, wr_mask, input rd_data, rd_valid);
    modport slave  (input cmd, addr, wr_data, wr_mask, output rd_data, rd_valid);
endinterface

// File: rtl/sdram_rd_pipe.sv
// CAS-latency read valid pipe and read-data capture register.
// SDRAM_PHY_CHECK_EN adds a busy output for the bus-conflict checker.
module sdram_rd_pipe #(
    parameter int CAS_LAT    = 2,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_req,
    input  logic [DATA_WIDTH-1:0] dq_in,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
`ifdef SDRAM_PHY_CHECK_EN
    , output logic                busy
`endif
);
    // Command reaches the device one edge after sampling; data follows CAS_LAT edges later.
    logic [CAS_LAT:0] vld_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[CAS_LAT-1:0], rd_req};
            rd_valid <= vld_pipe[CAS_LAT];
            if (vld_pipe[CAS_LAT]) rd_data <= dq_in;
        end
    end

`ifdef SDRAM_PHY_CHECK_EN
    assign busy = |vld_pipe;
`endif
endmodule

// File: rtl/sdram_cmd_phy.sv
// SDRAM command PHY: abstract command -> registered SDRAM pins, write drive, CAS-latency read capture.
// SDRAM_PHY_CHECK_EN adds a sticky protocol error output err.
module sdram_cmd_phy
    import sdram_pkg::*;
#(
    parameter int              ROW_BITS   = 12,
    parameter int              COL_BITS   = 9,
    parameter int              BANK_BITS  = 2,
    parameter int              DATA_WIDTH = 16,
    parameter int              CAS_LAT    = 2,
    parameter logic [ROW_BITS-1:0] MODE_REG = 12'h020
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sdram_cmd_phy_if.slave          core,
    output logic                    sd_cke,
    output logic                    sd_cs_n,
    output logic                    sd_ras_n,
    output logic                    sd_cas_n,
    output logic                    sd_we_n,
    output logic [BANK_BITS-1:0]    sd_ba,
    output logic [ROW_BITS-1:0]     sd_a,
    output logic [DATA_WIDTH/8-1:0] sd_dqm,
    output logic [DATA_WIDTH-1:0]   sd_dq_out,
    output logic                    sd_dq_oe,
    input  logic [DATA_WIDTH-1:0]   sd_dq_in
`ifdef SDRAM_PHY_CHECK_EN
    , output logic                  err
`endif
);
    localparam int AW = BANK_BITS + ROW_BITS + COL_BITS;

    logic [BANK_BITS-1:0] bank_q;
    logic [ROW_BITS-1:0]  row_q;
    logic [COL_BITS-1:0]  col_q;
    logic                 lp_q, lp_nxt, cke_nxt, rd, wr;
    logic [3:0]           pin_nxt;
    logic [BANK_BITS-1:0] ba_nxt;
    logic [ROW_BITS-1:0]  a_nxt;

    always_comb begin
        pin_nxt = PIN_NOP;
        ba_nxt  = '0;
        a_nxt   = '0;
        cke_nxt = sd_cke;
        lp_nxt  = lp_q;
        rd      = 1'b0;
        wr      = 1'b0;
        case (core.cmd)
            CMD_DESL: pin_nxt = PIN_DESL;
            CMD_NOP, CMD_REC: begin cke_nxt = 1'b1; lp_nxt = 1'b0; end
            CMD_MRS: begin pin_nxt = PIN_MRS; a_nxt = MODE_REG; end
            CMD_ACT: begin
                pin_nxt = PIN_ACT;
                ba_nxt  = core.addr[AW-1 -: BANK_BITS];
                a_nxt   = core.addr[COL_BITS +: ROW_BITS];
            end
            CMD_READ, CMD_READA, CMD_WRIT, CMD_WRITA: begin
                rd      = is_read(core.cmd);
                wr      = is_write(core.cmd);
                pin_nxt = rd ? PIN_READ : PIN_WRIT;
                ba_nxt  = bank_q;
                a_nxt[COL_BITS-1:0] = col_q;
                a_nxt[A10] = (core.cmd == CMD_READA) || (core.cmd == CMD_WRITA);
            end
            CMD_PRE:  begin pin_nxt = PIN_PRE; ba_nxt = bank_q; end
            CMD_PALL: begin pin_nxt = PIN_PRE; a_nxt[A10] = 1'b1; end
            CMD_BST:  pin_nxt = PIN_BST;
            CMD_REF:  pin_nxt = PIN_REF;
            CMD_SELF: begin pin_nxt = PIN_REF; cke_nxt = 1'b0; lp_nxt = 1'b1; end
            CMD_SUP:  begin cke_nxt = 1'b0; lp_nxt = 1'b1; end
            default:  pin_nxt = PIN_NOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} <= PIN_DESL;
            sd_cke    <= 1'b1;
            lp_q      <= 1'b0;
            sd_ba     <= '0;
            sd_a      <= '0;
            sd_dqm    <= '1;
            sd_dq_out <= '0;
            sd_dq_oe  <= 1'b0;
            bank_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
        end else begin
            {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} <= pin_nxt;
            sd_cke   <= cke_nxt;
            lp_q     <= lp_nxt;
            sd_ba    <= ba_nxt;
            sd_a     <= a_nxt;
            sd_dqm   <= wr ? core.wr_mask : '0;
            sd_dq_oe <= wr;
            if (wr) sd_dq_out <= core.wr_data;
            if (core.cmd == CMD_ACT)
                {bank_q, row_q, col_q} <= core.addr;
        end
    end

`ifdef SDRAM_PHY_CHECK_EN
    logic rd_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else if ((wr && rd_busy) || core.cmd == CMD_ILL ||
                 (lp_q && !(core.cmd inside {CMD_NOP, CMD_REC, CMD_DESL})))
            err <= 1'b1;
    end
`endif

    sdram_rd_pipe #(.CAS_LAT(CAS_LAT), .DATA_WIDTH(DATA_WIDTH)) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_req   (rd),
        .dq_in    (sd_dq_in),
        .rd_data  (core.rd_data),
        .rd_valid (core.rd_valid)
`ifdef SDRAM_PHY_CHECK_EN
        , .busy   (rd_busy)
`endif
    );
endmodule
